// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: parity modes, FSM encodings
// and the bit-counter width helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full is only accepted
// when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Configurable UART receiver: Rx synchroniser, 3-sample majority vote, framing
// FSM with parity/stop checks, and a receive FIFO with sticky overrun.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a falling edge
// ST_START     | inside start bit, rejects glitches at mid-bit
// ST_DATA      | shifting in data bits, LSB first
// ST_PARITY    | sampling the parity bit
// ST_STOP      | sampling stop bit(s); last one pushes the word
// ST_WAIT_IDLE | stop bit was low, waiting for the line to return high
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 30,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Ready,
    input  logic                 Ack,
    output logic                 Overrun,
    input  logic                 ClrOverrun
);
    localparam int CW = cnt_width(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int M  = CLK_DIV / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_S2   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] IDX_ONE   = BW'(1);

    logic [1:0]           rst_pipe;
    logic                 rst_n;
    logic                 rx_meta, rxs;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 s0, s1, maj;
    logic                 par_err, frame_err;
    logic                 sample, end_bit, push;
    logic                 fifo_full, fifo_empty, pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [DATA_BITS+1:0] head;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) rst_pipe <= '0;
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rxs     <= rx_meta;
        end
    end

    assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign sample  = (cnt == CNT_S2);
    assign end_bit = (cnt == CNT_LAST);
    assign push    = (state == ST_STOP) && sample && (bit_idx == LAST_STOP);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (cnt == CNT_S0) s0 <= rxs;
            if (cnt == CNT_S1) s1 <= rxs;
            if (state != ST_IDLE && state != ST_WAIT_IDLE)
                cnt <= end_bit ? '0 : cnt + CNT_ONE;
            case (state)
                ST_IDLE: if (!rxs) begin
                    cnt       <= '0;
                    bit_idx   <= '0;
                    par_err   <= 1'b0;
                    frame_err <= 1'b0;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (sample && maj) state <= ST_IDLE;
                    else if (end_bit)  state <= ST_DATA;
                end
                ST_DATA: begin
                    if (sample) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (end_bit) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    // Odd parity expects an XOR of 1 over data+parity, even expects 0.
                    if (sample)  par_err <= ((^shreg) ^ maj) == (PARITY == PARITY_EVEN);
                    if (end_bit) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (sample) begin
                        if (!maj) frame_err <= 1'b1;
                        if (bit_idx == LAST_STOP) state <= maj ? ST_IDLE : ST_WAIT_IDLE;
                    end else if (end_bit) begin
                        bit_idx <= bit_idx + IDX_ONE;
                    end
                end
                ST_WAIT_IDLE: if (rxs) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop = Ack & ~fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({frame_err | ~maj, par_err, shreg}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign Ready     = (fifo_count != '0);
    assign Data      = head[DATA_BITS-1:0];
    assign ParityErr = head[DATA_BITS];
    assign FrameErr  = head[DATA_BITS+1];

    // Set wins over a simultaneous clear.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)                     Overrun <= 1'b0;
        else if (push & fifo_full & ~pop) Overrun <= 1'b1;
        else if (ClrOverrun)            Overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 instance and an even-parity instance.
module tb_uart_rx_framed;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       rx_a = 1'b1, ack_a = 1'b0, clr_a = 1'b0;
    logic       rx_p = 1'b1, ack_p = 1'b0, clr_p = 1'b0;
    logic [7:0] data_a, data_p;
    logic       pe_a, fe_a, ready_a, ovr_a;
    logic       pe_p, fe_p, ready_p, ovr_p;
    int         total = 0;
    int         bad = 0;

    always #5 Clk = ~Clk;

    uart_rx_framed #(.DATA_BITS(8), .CLK_DIV(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .Clk(Clk), .nReset(nReset), .Rx(rx_a), .Data(data_a), .ParityErr(pe_a), .FrameErr(fe_a),
        .Ready(ready_a), .Ack(ack_a), .Overrun(ovr_a), .ClrOverrun(clr_a));

    uart_rx_framed #(.DATA_BITS(8), .CLK_DIV(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
        .Clk(Clk), .nReset(nReset), .Rx(rx_p), .Data(data_p), .ParityErr(pe_p), .FrameErr(fe_p),
        .Ready(ready_p), .Ack(ack_p), .Overrun(ovr_p), .ClrOverrun(clr_p));

    task automatic clk_n(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx_p = v;
        else       rx_a = v;
    endtask

    task automatic tx_head(input bit which, input logic [7:0] d, input bit has_par, input logic parbit);
        set_line(which, 1'b0);
        clk_n(16);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            clk_n(16);
        end
        if (has_par) begin
            set_line(which, parbit);
            clk_n(16);
        end
    endtask

    task automatic tx(input bit which, input logic [7:0] d, input bit has_par, input logic parbit);
        tx_head(which, d, has_par, parbit);
        set_line(which, 1'b1);
        clk_n(48);
    endtask

    task automatic pop_a();
        ack_a = 1'b1; clk_n(1); ack_a = 1'b0;
    endtask

    task automatic pop_p();
        ack_p = 1'b1; clk_n(1); ack_p = 1'b0;
    endtask

    task automatic test_reset();
        clk_n(3);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_a); end
        total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_a); end
        total++; if ({pe_a, fe_a} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {pe_a, fe_a}); end
        total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
        total++; if (ready_p !== 1'b0) begin bad++; $display("FAIL reset_ready_p: got %b want 0", ready_p); end
        nReset = 1'b1;
        clk_n(8);
    endtask

    task automatic test_basic();
        tx_head(0, 8'hA5, 0, 1'b0);
        set_line(0, 1'b1);
        clk_n(12);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL basic_ready_early: got %b want 0", ready_a); end
        clk_n(1);
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL basic_ready_rise: got %b want 1", ready_a); end
        total++; if (data_a !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", data_a); end
        total++; if ({pe_a, fe_a} !== 2'b00) begin bad++; $display("FAIL basic_flags: got %b want 00", {pe_a, fe_a}); end
        clk_n(35);
        pop_a();
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL basic_ready_pop: got %b want 0", ready_a); end
    endtask

    task automatic test_parity();
        tx(1, 8'h03, 1, 1'b1);
        total++; if (ready_p !== 1'b1) begin bad++; $display("FAIL par_ready1: got %b want 1", ready_p); end
        total++; if (data_p !== 8'h03) begin bad++; $display("FAIL par_data1: got %h want 03", data_p); end
        total++; if (pe_p !== 1'b1) begin bad++; $display("FAIL par_err1: got %b want 1", pe_p); end
        total++; if (fe_p !== 1'b0) begin bad++; $display("FAIL par_fe1: got %b want 0", fe_p); end
        pop_p();
        tx(1, 8'h03, 1, 1'b0);
        total++; if (data_p !== 8'h03) begin bad++; $display("FAIL par_data2: got %h want 03", data_p); end
        total++; if (pe_p !== 1'b0) begin bad++; $display("FAIL par_err2: got %b want 0", pe_p); end
        pop_p();
        tx(1, 8'h07, 1, 1'b1);
        total++; if ({data_p, pe_p} !== {8'h07, 1'b0}) begin bad++; $display("FAIL par_data3: got %h/%b want 07/0", data_p, pe_p); end
        pop_p();
        total++; if (ready_p !== 1'b0) begin bad++; $display("FAIL par_empty: got %b want 0", ready_p); end
    endtask

    task automatic test_framing();
        tx_head(0, 8'h3C, 0, 1'b0);
        set_line(0, 1'b0);
        clk_n(64);
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL frame_ready: got %b want 1", ready_a); end
        total++; if (data_a !== 8'h3C) begin bad++; $display("FAIL frame_data: got %h want 3c", data_a); end
        total++; if ({fe_a, pe_a} !== 2'b10) begin bad++; $display("FAIL frame_flags: got %b want 10", {fe_a, pe_a}); end
        set_line(0, 1'b1);
        clk_n(192);
        pop_a();
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL frame_no_extra: got %b want 0", ready_a); end
    endtask

    task automatic test_glitch();
        set_line(0, 1'b0); clk_n(1); set_line(0, 1'b1);
        clk_n(40);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL glitch1_ready: got %b want 0", ready_a); end
        set_line(0, 1'b0); clk_n(4); set_line(0, 1'b1);
        clk_n(40);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL glitch4_ready: got %b want 0", ready_a); end
        tx(0, 8'h96, 0, 1'b0);
        total++; if ({ready_a, data_a} !== {1'b1, 8'h96}) begin bad++; $display("FAIL glitch_after: got %b/%h want 1/96", ready_a, data_a); end
        pop_a();
    endtask

    task automatic test_overrun();
        logic [7:0] words [5];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        for (int i = 0; i < 4; i++) tx(0, words[i], 0, 1'b0);
        total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL ovr_full_no_set: got %b want 0", ovr_a); end
        tx(0, words[4], 0, 1'b0);
        total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ovr_a); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({ready_a, data_a} !== {1'b1, words[i]}) begin bad++; $display("FAIL ovr_pop%0d: got %b/%h want 1/%h", i, ready_a, data_a, words[i]); end
            pop_a();
        end
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL ovr_fifth_dropped: got %b want 0", ready_a); end
        total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
        clr_a = 1'b1; clk_n(1); clr_a = 1'b0;
        total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", ovr_a); end
    endtask

    task automatic test_back_to_back();
        tx(0, 8'hC3, 0, 1'b0);
        tx(0, 8'h3C, 0, 1'b0);
        total++; if (data_a !== 8'hC3) begin bad++; $display("FAIL b2b_head: got %h want c3", data_a); end
        ack_a = 1'b1;
        clk_n(1);
        total++; if ({ready_a, data_a} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL b2b_second: got %b/%h want 1/3c", ready_a, data_a); end
        clk_n(1);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", ready_a); end
        clk_n(2);
        ack_a = 1'b0;
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL b2b_pop_empty: got %b want 0", ready_a); end
    endtask

    task automatic test_reset_mid();
        set_line(0, 1'b0); clk_n(16);
        set_line(0, 1'b1); clk_n(40);
        nReset = 1'b0;
        clk_n(3);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", ready_a); end
        total++; if (data_a !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", data_a); end
        nReset = 1'b1;
        clk_n(20);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_no_partial: got %b want 0", ready_a); end
        tx(0, 8'h5A, 0, 1'b0);
        total++; if ({ready_a, data_a} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL rstmid_word: got %b/%h want 1/5a", ready_a, data_a); end
        total++; if ({pe_a, fe_a, ovr_a} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b want 000", {pe_a, fe_a, ovr_a}); end
        pop_a();
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_single: got %b want 0", ready_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. Adds configurable data width, optional parity, 1 or 2 stop bits, 3-sample majority voting, per-word error flags, and a small receive FIFO with overrun detection. Sits between the Rx pin and the host-side consumer, using the same Ready/Ack pop handshake.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, LSB first
CLK_DIV, 30, Clk cycles per bit, >= 8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of 2, >= 2

Ports:
Clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
Rx  in  1  serial line, idle high, asynchronous to Clk
Data  out  DATA_BITS  head-of-FIFO data word
ParityErr  out  1  parity error flag for the head word; 0 when PARITY = 0
FrameErr  out  1  head word had a 0 sampled in a stop bit
Ready  out  1  FIFO non-empty; Data and flags valid
Ack  in  1  pops the head word on any cycle with Ready & Ack
Overrun  out  1  sticky: a complete frame arrived while the FIFO was full
ClrOverrun  in  1  clears Overrun for one cycle

Behaviour:
- Reset (async assert, sync-released internally): Ready = 0, Data = 0, ParityErr = 0, FrameErr = 0, Overrun = 0, FIFO empty, FSM in IDLE, Rx synchroniser = 1.
- Rx passes through a 2-FF synchroniser (reset value 1). All decisions use the synchronised value rxs.
- Bit counter width is clog2(CLK_DIV). Mid-bit position M = CLK_DIV/2 (integer).
- Sampling: bit value = majority of rxs at counts M-1, M, M+1 of each bit period.
- States:
  - IDLE: on rxs = 0, clear counter and go to START.
  - START: at count M+1, if majority = 1 (glitch), return to IDLE with no push and no error. Else go to DATA at the end of the period.
  - DATA: shift in DATA_BITS bits LSB first. Go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample the parity bit. Error if the XOR of data and parity bit = 0 for odd parity, or = 1 for even parity.
  - STOP: sample STOP_BITS stop bits. Any 0 sets the frame error. At the M+1 sample of the last stop bit, push {FrameErr, ParityErr, Data} and go to WAIT_IDLE. This sample point is the push cycle.
  - WAIT_IDLE: stay while rxs = 0 (break or bad stop bit). Go to IDLE on rxs = 1. If the last stop bit sampled 1, go straight to IDLE on that same cycle.
- Push latency: Ready rises on the cycle after the push cycle when the FIFO was empty.
- FIFO: first-word-fall-through. Data and flags are driven from the head entry.
  - Pop happens on Ready & Ack.
  - Simultaneous push and pop when full is allowed: both take effect and the count is unchanged.
  - Push when full with no pop: the word is dropped, Overrun is set, and the FIFO contents are untouched.
  - Pop when empty: ignored.
- Overrun: ClrOverrun clears it. A set and a clear in the same cycle results in set (set wins).
- Ack held high: pops one word per cycle while Ready is high.
- Reset mid-frame: abort immediately and discard the partial word.
- Pointers wrap modulo FIFO_DEPTH. The count register is clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PARITY_NONE / ODD / EVEN;
  - FSM state encodings IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
  - a helper function for the counter width.
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO, parametrised on width and depth, with async active-low reset and push/pop/full/empty/count.
- The receiver FSM, synchroniser and majority voter stay in uart_rx_framed.

Test Plan:
- CLK_DIV = 16, 8N1: send 0xA5, no Ack → Ready rises 1 cycle after the stop-bit sample; Data = 0xA5, ParityErr = 0, FrameErr = 0. Assert Ack for 1 cycle → Ready = 0.
- PARITY = 2 (even), send 0x03 with parity bit 1 → ParityErr = 1, Data = 0x03. Repeat with parity bit 0 → ParityErr = 0.
- Hold stop bit low, then line low for 3 bit times → word pushed with FrameErr = 1; no new frame starts until Rx returns high.
- 1-cycle-wide and CLK_DIV/4-wide low pulses on an idle line → no push, FSM back in IDLE, Ready stays 0.
- FIFO_DEPTH = 4: send 5 frames without Ack → first 4 pop back in order, 5th dropped, Overrun = 1. Pulse ClrOverrun → Overrun = 0.
- Deassert nReset mid-DATA, release, send 0x5A → only 0x5A is received; no partial word, all flags 0.
